i2s_rx_capture: RTL

I2S record-path receiver, the capture counterpart of the playback serializer. Oversamples codec BCLK/RECLRC/RECDAT in the mclk domain and deserializes standard I2S (1-bit delay, MSB-first) stereo frames. Buffers {left,right} pairs in a small FIFO with a valid/ready stream interface. Feeds the audio combinator and BRAM DMA as a live-input source.

---
 rtl/i2s_rx_capture_pkg.sv | 19 +
 rtl/i2s_rx_capture_fifo.sv | 98 +++++++++
 rtl/i2s_rx_capture.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_capture_pkg.sv
// Shared audio definitions for the I2S record path: default sample width,
// stereo pair layout and receiver FSM state encoding.
package i2s_rx_capture_pkg;

  localparam int SAMPLE_BITS_DEF = 16;

  typedef struct packed {
    logic signed [SAMPLE_BITS_DEF-1:0] left;
    logic signed [SAMPLE_BITS_DEF-1:0] right;
  } stereo_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LEFT = 2'd1,
    ST_LEFT      = 2'd2,
    ST_RIGHT     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_capture_fifo.sv
// Synchronous show-ahead FIFO with registered read data, fill level,
// drop-on-full and a sticky overflow flag.
module i2s_rx_fifo
  import i2s_rx_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop_ready,
  input  logic                   clear_overflow,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [AW:0]      count_r, count_s;
  logic [WIDTH-1:0] rd_data_r, head_s;
  logic             valid_r, overflow_r;
  logic             pop_s, full_s, wr_s, drop_s;

  assign pop_s  = valid_r & pop_ready;
  assign full_s = (count_r == FULL_CNT);
  assign wr_s   = push & (~full_s | pop_s);
  assign drop_s = push & full_s & ~pop_s;

  // Next read pointer, occupancy and the entry that becomes the head
  always_comb begin
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    head_s   = mem_r[rd_ptr_r];
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    case ({wr_s, pop_s})
      2'b10:   count_s = count_r + 1'b1;
      2'b01:   count_s = count_r - 1'b1;
      default: count_s = count_r;
    endcase
    // A write into an empty (or just-emptied) FIFO bypasses the array
    if (wr_s && (wr_ptr_r == rd_ptr_s)) begin
      head_s = push_data;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, registered read data and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      rd_data_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      valid_r  <= (count_s != '0);
      if (count_s != '0) begin
        rd_data_r <= head_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign rd_data    = rd_data_r;
  assign rd_valid   = valid_r;
  assign fill_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S record-path receiver: oversamples BCLK/LRCLK/RECDAT in mclk, deserializes
// stereo frames into a FIFO stream. Define I2S_RX_PEAK_EN for per-channel peak meters.
module i2s_rx_capture
  import i2s_rx_capture_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SLOT_BITS   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic                        i2s_bclk,
  input  logic                        i2s_lrclk,
  input  logic                        i2s_recdat,
  input  logic                        enable,
  output logic [2*SAMPLE_BITS-1:0]    m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  input  logic                        clear_overflow,
  output logic                        frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  input  logic                        peak_clear,
  output logic [SAMPLE_BITS-2:0]      peak_l,
  output logic [SAMPLE_BITS-2:0]      peak_r
`endif
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] SAMPLE_CNT  = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_BITS - 1);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT_MAX    = CW'(SLOT_BITS);

  logic [SYNC_STAGES-1:0] bclk_sync_r, lr_sync_r, dat_sync_r;
  logic                   bclk_prev_r, lr_last_r, frame_err_r;
  logic [CW-1:0]          bitcnt_r;
  logic [SAMPLE_BITS-1:0] shift_r, left_r, word_s;
  rx_state_t              state_r, state_n;
  logic bclk_s, lr_s, dat_s, rise_s, lr_change_s, bit_rise_s;
  logic shift_en_s, word_done_s, slot_over_s, short_slot_s;
  logic push_s, err_s, latch_left_s;

  // Input synchronizers and bclk edge history
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bclk_sync_r <= '0;
      lr_sync_r   <= '0;
      dat_sync_r  <= '0;
      bclk_prev_r <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i2s_bclk};
      lr_sync_r   <= {lr_sync_r[SYNC_STAGES-2:0], i2s_lrclk};
      dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], i2s_recdat};
      bclk_prev_r <= bclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign bclk_s       = bclk_sync_r[SYNC_STAGES-1];
  assign lr_s         = lr_sync_r[SYNC_STAGES-1];
  assign dat_s        = dat_sync_r[SYNC_STAGES-1];
  assign rise_s       = bclk_s & ~bclk_prev_r;
  assign lr_change_s  = rise_s & (lr_s != lr_last_r);
  assign bit_rise_s   = rise_s & (lr_s == lr_last_r);
  assign shift_en_s   = bit_rise_s & (bitcnt_r < SAMPLE_CNT);
  assign word_done_s  = bit_rise_s & (bitcnt_r == SAMPLE_LAST);
  assign slot_over_s  = bit_rise_s & (bitcnt_r == SLOT_LAST);
  assign short_slot_s = lr_change_s & (bitcnt_r < SAMPLE_CNT);
  assign word_s       = {shift_r[SAMPLE_BITS-2:0], dat_s};

  // Receiver FSM state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Receiver FSM next state, push and frame-error decode
  always_comb begin
    state_n      = state_r;
    push_s       = 1'b0;
    err_s        = 1'b0;
    latch_left_s = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_n = ST_WAIT_LEFT;
        ST_WAIT_LEFT: begin
          if (lr_change_s && !lr_s) begin
            state_n = ST_LEFT;
          end else begin
            state_n = ST_WAIT_LEFT;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (short_slot_s || slot_over_s) begin
            err_s   = 1'b1;
            state_n = ST_WAIT_LEFT;
          end else if (lr_change_s) begin
            state_n = (state_r == ST_LEFT) ? ST_RIGHT : ST_LEFT;
          end else begin
            latch_left_s = word_done_s & (state_r == ST_LEFT);
            push_s       = word_done_s & (state_r == ST_RIGHT);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Slot bit counter, shift register, left word and error pulse
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bitcnt_r    <= '0;
      lr_last_r   <= 1'b0;
      shift_r     <= '0;
      left_r      <= '0;
      frame_err_r <= 1'b0;
    end else begin
      if (lr_change_s) begin
        bitcnt_r  <= '0;
        lr_last_r <= lr_s;
      end else if (bit_rise_s && (bitcnt_r != SLOT_MAX)) begin
        bitcnt_r <= bitcnt_r + 1'b1;
      end
      if (shift_en_s) begin
        shift_r <= word_s;
      end
      if (latch_left_s) begin
        left_r <= word_s;
      end
      frame_err_r <= err_s;
    end
  end

  assign frame_err = frame_err_r;

  i2s_rx_fifo #(
    .WIDTH (2*SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (mclk),
    .rst            (rst),
    .push           (push_s),
    .push_data      ({left_r, word_s}),
    .pop_ready      (m_tready),
    .clear_overflow (clear_overflow),
    .rd_data        (m_tdata),
    .rd_valid       (m_tvalid),
    .fill_level     (fill_level),
    .overflow       (overflow)
  );

`ifdef I2S_RX_PEAK_EN
  logic [SAMPLE_BITS-2:0] peak_l_r, peak_r_r, base_l_s, base_r_s, abs_l_s, abs_r_s;

  // Magnitude with the most negative code clamped to full-scale positive
  function automatic logic [SAMPLE_BITS-2:0] abs_sat(input logic [SAMPLE_BITS-1:0] s);
    logic [SAMPLE_BITS-1:0] neg;
    neg = ~s + 1'b1;
    if (!s[SAMPLE_BITS-1]) begin
      abs_sat = s[SAMPLE_BITS-2:0];
    end else if (neg[SAMPLE_BITS-1]) begin
      abs_sat = '1;
    end else begin
      abs_sat = neg[SAMPLE_BITS-2:0];
    end
  endfunction

  // Peak candidates; a clear in the same cycle as a push starts from zero
  always_comb begin
    base_l_s = peak_clear ? '0 : peak_l_r;
    base_r_s = peak_clear ? '0 : peak_r_r;
    abs_l_s  = abs_sat(left_r);
    abs_r_s  = abs_sat(word_s);
  end

  // Peak hold registers
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      peak_l_r <= '0;
      peak_r_r <= '0;
    end else begin
      peak_l_r <= (push_s && (abs_l_s > base_l_s)) ? abs_l_s : base_l_s;
      peak_r_r <= (push_s && (abs_r_s > base_r_s)) ? abs_r_s : base_r_s;
    end
  end

  assign peak_l = peak_l_r;
  assign peak_r = peak_r_r;
`endif

endmodule
